// File: rtl/ex_stage.sv
// MIPS execute stage: combinational ALU, branch-target adder and a
// 32-iteration HI/LO multiply/divide unit with a stall back to the front end.
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        Valid_ID,
    input  logic [31:0] PC_plus4_ID,
    input  logic [31:0] Read_Data_1_ID,
    input  logic [31:0] Read_Data_2_ID,
    input  logic [31:0] Sign_ext_ID,
    input  logic [4:0]  Rt_ID,
    input  logic [4:0]  Rd_ID,
    input  logic        RegDst_ID,
    input  logic        ALUSrc_ID,
    input  logic [1:0]  ALUOp_ID,
    input  logic        RegWrite_ID,
    output logic [31:0] ALU_result_EX,
    output logic        Zero_EX,
    output logic [31:0] PC_next_EX,
    output logic [4:0]  Write_register_EX,
    output logic        RegWrite_EX,
    output logic        Stall_EX,
    output logic        Busy_EX
);
    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] wh_q, wh_d, wl_q, wl_d;     // working high/low halves
    logic [31:0] dvs_q, dvs_d, dvd_q, dvd_d;
    logic        is_div_q, is_div_d, neg_q, neg_d, neg_r_q, neg_r_d, dz_q, dz_d;

    logic [31:0] a, b, op_b;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic        rtype, hilo_op, muldiv_op, mthi, mtlo, issue;
    logic        sgn, a_neg, b_neg;
    logic [31:0] alu_res;
    logic [32:0] sum33, rem33;
    logic [31:0] diff, step_hi, step_lo, q_fin, r_fin;
    logic        ge;
    logic [63:0] prod;

    assign a         = Read_Data_1_ID;
    assign b         = Read_Data_2_ID;
    assign op_b      = ALUSrc_ID ? Sign_ext_ID : b;
    assign funct     = Sign_ext_ID[5:0];
    assign shamt     = Sign_ext_ID[10:6];
    assign rtype     = Valid_ID && (ALUOp_ID == 2'b10);
    assign muldiv_op = rtype && (funct[5:2] == 4'b0110);
    assign hilo_op   = rtype && ((funct[5:2] == 4'b0100) || muldiv_op);
    assign mthi      = rtype && (funct == 6'b010001);
    assign mtlo      = rtype && (funct == 6'b010011);

    assign Busy_EX   = (state_q == S_BUSY);
    assign Stall_EX  = hilo_op && Busy_EX && !reset;
    assign issue     = muldiv_op && !Stall_EX && (state_q == S_IDLE);

    always_comb begin
        alu_res = a + op_b;
        if (ALUOp_ID == 2'b01) begin
            alu_res = a - op_b;
        end else if (ALUOp_ID == 2'b10) begin
            case (funct)
                6'b100000, 6'b100001: alu_res = a + op_b;
                6'b100010, 6'b100011: alu_res = a - op_b;
                6'b100100: alu_res = a & op_b;
                6'b100101: alu_res = a | op_b;
                6'b100110: alu_res = a ^ op_b;
                6'b100111: alu_res = ~(a | op_b);
                6'b101010: alu_res = {31'd0, $signed(a) < $signed(op_b)};
                6'b101011: alu_res = {31'd0, a < op_b};
                6'b000000: alu_res = op_b << shamt;
                6'b000010: alu_res = op_b >> shamt;
                6'b000011: alu_res = $signed(op_b) >>> shamt;
                6'b010000: alu_res = hi_q;
                6'b010010: alu_res = lo_q;
                default:   alu_res = 32'd0;
            endcase
        end
    end

    assign ALU_result_EX     = alu_res;
    assign Zero_EX           = (alu_res == 32'd0);
    assign PC_next_EX        = PC_plus4_ID + (Sign_ext_ID << 2);
    assign Write_register_EX = RegDst_ID ? Rd_ID : Rt_ID;
    assign RegWrite_EX       = RegWrite_ID && Valid_ID && !Stall_EX && !(mthi || mtlo || muldiv_op);

    // One iteration: shift-add multiply or restoring divide on magnitudes
    always_comb begin
        sum33 = {1'b0, wh_q} + (wl_q[0] ? {1'b0, dvs_q} : 33'd0);
        rem33 = {wh_q, wl_q[31]};
        ge    = rem33 >= {1'b0, dvs_q};
        diff  = rem33[31:0] - dvs_q;
        if (is_div_q) begin
            step_hi = ge ? diff : rem33[31:0];
            step_lo = {wl_q[30:0], ge};
        end else begin
            step_hi = sum33[32:1];
            step_lo = {sum33[0], wl_q[31:1]};
        end
        prod  = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        q_fin = neg_q ? -step_lo : step_lo;
        r_fin = neg_r_q ? -step_hi : step_hi;
    end

    assign sgn   = !funct[0];
    assign a_neg = sgn && a[31];
    assign b_neg = sgn && b[31];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        wh_d     = wh_q;
        wl_d     = wl_q;
        dvs_d    = dvs_q;
        dvd_d    = dvd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        neg_r_d  = neg_r_q;
        dz_d     = dz_q;
        case (state_q)
            S_IDLE: begin
                if (mthi) hi_d = a;
                if (mtlo) lo_d = a;
                if (issue) begin
                    state_d  = S_BUSY;
                    cnt_d    = 5'd0;
                    wh_d     = 32'd0;
                    wl_d     = a_neg ? -a : a;
                    dvs_d    = b_neg ? -b : b;
                    dvd_d    = a;
                    is_div_d = funct[1];
                    neg_d    = a_neg ^ b_neg;
                    neg_r_d  = a_neg;
                    dz_d     = funct[1] && (b == 32'd0);
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 5'd1;
                wh_d  = step_hi;
                wl_d  = step_lo;
                if (cnt_q == 5'd31) begin
                    state_d = S_IDLE;
                    if (!is_div_q) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (dz_q) begin
                        hi_d = dvd_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = r_fin;
                        lo_d = q_fin;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            wh_q     <= 32'd0;
            wl_q     <= 32'd0;
            dvs_q    <= 32'd0;
            dvd_q    <= 32'd0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            wh_q     <= wh_d;
            wl_q     <= wl_d;
            dvs_q    <= dvs_d;
            dvd_q    <= dvd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            neg_r_q  <= neg_r_d;
            dz_q     <= dz_d;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver queues the expected retire of each
// instruction, the monitor compares when a valid instruction leaves unstalled.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        Valid_ID;
    logic [31:0] PC_plus4_ID, Read_Data_1_ID, Read_Data_2_ID, Sign_ext_ID;
    logic [4:0]  Rt_ID, Rd_ID;
    logic        RegDst_ID, ALUSrc_ID, RegWrite_ID;
    logic [1:0]  ALUOp_ID;
    logic [31:0] ALU_result_EX, PC_next_EX;
    logic        Zero_EX, RegWrite_EX, Stall_EX, Busy_EX;
    logic [4:0]  Write_register_EX;

    ex_stage dut (
        .clk(clk), .reset(reset), .Valid_ID(Valid_ID), .PC_plus4_ID(PC_plus4_ID),
        .Read_Data_1_ID(Read_Data_1_ID), .Read_Data_2_ID(Read_Data_2_ID),
        .Sign_ext_ID(Sign_ext_ID), .Rt_ID(Rt_ID), .Rd_ID(Rd_ID), .RegDst_ID(RegDst_ID),
        .ALUSrc_ID(ALUSrc_ID), .ALUOp_ID(ALUOp_ID), .RegWrite_ID(RegWrite_ID),
        .ALU_result_EX(ALU_result_EX), .Zero_EX(Zero_EX), .PC_next_EX(PC_next_EX),
        .Write_register_EX(Write_register_EX), .RegWrite_EX(RegWrite_EX),
        .Stall_EX(Stall_EX), .Busy_EX(Busy_EX)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        rw;
        logic [4:0]  wreg;
        int          stall;
        logic        busy;
        logic        chkpc;
        logic [31:0] pcn;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic done = 1'b0;

    task automatic chk(input string name, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %h, expected %h", name, what, act, exp);
        end
    endtask

    task automatic issue(input string name, input logic [1:0] op, input logic src, input logic [31:0] sx,
                         input logic [31:0] a, input logic [31:0] b, input logic rdst, input logic rw,
                         input logic [31:0] pc, input logic [31:0] eres, input logic erw, input int estall,
                         input logic ebusy, input logic chkpc, input logic [31:0] epc);
        exp_t e;
        int   guard;
        e.name = name; e.res = eres; e.rw = erw; e.wreg = rdst ? 5'd3 : 5'd2;
        e.stall = estall; e.busy = ebusy; e.chkpc = chkpc; e.pcn = epc;
        q.push_back(e);
        Valid_ID = 1'b1; ALUOp_ID = op; ALUSrc_ID = src; Sign_ext_ID = sx;
        Read_Data_1_ID = a; Read_Data_2_ID = b; RegDst_ID = rdst; RegWrite_ID = rw;
        PC_plus4_ID = pc; Rt_ID = 5'd2; Rd_ID = 5'd3;
        guard = 0;
        @(negedge clk);
        while (Stall_EX && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
    endtask

    // R-type shortcut: ALUOp 10, RegDst=1, RegWrite_ID=1
    task automatic r(input string name, input logic [5:0] funct, input logic [4:0] sh,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] eres,
                     input logic erw, input int estall, input logic ebusy);
        issue(name, 2'b10, 1'b0, {21'd0, sh, funct}, a, b, 1'b1, 1'b1, 32'd0,
              eres, erw, estall, ebusy, 1'b0, 32'd0);
    endtask

    task automatic idle(input int n);
        Valid_ID = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;
    localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;

    // Driver
    initial begin
        reset = 1'b1; Valid_ID = 1'b0; ALUOp_ID = 2'b00; ALUSrc_ID = 1'b0; Sign_ext_ID = 32'd0;
        Read_Data_1_ID = 32'd0; Read_Data_2_ID = 32'd0; RegDst_ID = 1'b0; RegWrite_ID = 1'b0;
        PC_plus4_ID = 32'd0; Rt_ID = 5'd0; Rd_ID = 5'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        r("mfhi_rst", MFHI, 5'd0, 0, 0, 32'd0, 1'b1, 0, 1'b0);
        r("mflo_rst", MFLO, 5'd0, 0, 0, 32'd0, 1'b1, 0, 1'b0);
        r("add", 6'b100000, 5'd0, 5, 7, 32'd12, 1'b1, 0, 1'b0);
        issue("beq", 2'b01, 1'b0, 32'd4, 9, 9, 1'b0, 1'b0, 32'h100, 32'd0, 1'b0, 0, 1'b0, 1'b1, 32'h110);
        r("sub",  6'b100010, 5'd0, 3, 5, 32'hFFFF_FFFE, 1'b1, 0, 1'b0);
        r("and",  6'b100100, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b1, 0, 1'b0);
        r("or",   6'b100101, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b1, 0, 1'b0);
        r("xor",  6'b100110, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 0, 1'b0);
        r("nor",  6'b100111, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b1, 0, 1'b0);
        r("slt",  6'b101010, 5'd0, 32'hFFFF_FFFF, 1, 32'd1, 1'b1, 0, 1'b0);
        r("sltu", 6'b101011, 5'd0, 32'hFFFF_FFFF, 1, 32'd0, 1'b1, 0, 1'b0);
        r("sll",  6'b000000, 5'd4, 0, 1, 32'd16, 1'b1, 0, 1'b0);
        r("srl",  6'b000010, 5'd4, 0, 32'h8000_0000, 32'h0800_0000, 1'b1, 0, 1'b0);
        r("sra",  6'b000011, 5'd4, 0, 32'h8000_0000, 32'hF800_0000, 1'b1, 0, 1'b0);
        r("addu_wrap", 6'b100001, 5'd0, 32'hFFFF_FFFF, 1, 32'd0, 1'b1, 0, 1'b0);
        r("undef", 6'b111111, 5'd0, 5, 7, 32'd0, 1'b1, 0, 1'b0);
        issue("addi", 2'b00, 1'b1, 32'hFFFF_FFFF, 10, 99, 1'b0, 1'b1, 32'd0, 32'd9, 1'b1, 0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        issue("op11", 2'b11, 1'b0, 32'd0, 2, 3, 1'b0, 1'b1, 32'd0, 32'd5, 1'b1, 0, 1'b0, 1'b0, 32'd0);

        r("mult", MULT, 5'd0, 32'hFFFF_FFFD, 7, 32'd0, 1'b0, 0, 1'b0);
        r("mflo_mul", MFLO, 5'd0, 0, 0, 32'hFFFF_FFEB, 1'b1, 32, 1'b0);
        r("mfhi_mul", MFHI, 5'd0, 0, 0, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);

        r("divu", DIVU, 5'd0, 100, 7, 32'd0, 1'b0, 0, 1'b0);
        r("add_busy", 6'b100000, 5'd0, 1, 1, 32'd2, 1'b1, 0, 1'b1);
        r("mfhi_divu", MFHI, 5'd0, 0, 0, 32'd2, 1'b1, 31, 1'b0);
        r("mflo_divu", MFLO, 5'd0, 0, 0, 32'd14, 1'b1, 0, 1'b0);

        r("div_neg", DIV, 5'd0, 32'hFFFF_FFF9, 2, 32'd0, 1'b0, 0, 1'b0);
        r("mflo_div", MFLO, 5'd0, 0, 0, 32'hFFFF_FFFD, 1'b1, 32, 1'b0);
        r("mfhi_div", MFHI, 5'd0, 0, 0, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);

        r("div_zero", DIV, 5'd0, 5, 0, 32'd0, 1'b0, 0, 1'b0);
        r("mflo_dz", MFLO, 5'd0, 0, 0, 32'hFFFF_FFFF, 1'b1, 32, 1'b0);
        r("mfhi_dz", MFHI, 5'd0, 0, 0, 32'd5, 1'b1, 0, 1'b0);

        r("div_ovf", DIV, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, 1'b0);
        r("mflo_ovf", MFLO, 5'd0, 0, 0, 32'h8000_0000, 1'b1, 32, 1'b0);
        r("mfhi_ovf", MFHI, 5'd0, 0, 0, 32'd0, 1'b1, 0, 1'b0);

        r("multu_big", MULTU, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, 1'b0);
        r("mfhi_big", MFHI, 5'd0, 0, 0, 32'hFFFF_FFFE, 1'b1, 32, 1'b0);
        r("mflo_big", MFLO, 5'd0, 0, 0, 32'd1, 1'b1, 0, 1'b0);

        // Abort a multu with reset in its tenth busy cycle
        r("multu_abort", MULTU, 5'd0, 3, 4, 32'd0, 1'b0, 0, 1'b0);
        idle(9);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        r("mflo_abort", MFLO, 5'd0, 0, 0, 32'd0, 1'b1, 0, 1'b0);
        r("mthi", MTHI, 5'd0, 32'hABCD, 0, 32'd0, 1'b0, 0, 1'b0);
        r("mfhi_abcd", MFHI, 5'd0, 0, 0, 32'hABCD, 1'b1, 0, 1'b0);

        // A bubble carrying a mult encoding must not start the unit
        Sign_ext_ID = {26'd0, MULT}; ALUOp_ID = 2'b10; Read_Data_1_ID = 3; Read_Data_2_ID = 3;
        idle(2);
        r("mtlo", MTLO, 5'd0, 32'h55, 0, 32'd0, 1'b0, 0, 1'b0);
        r("mflo_55", MFLO, 5'd0, 0, 0, 32'h55, 1'b1, 0, 1'b0);
        r("mfhi_keep", MFHI, 5'd0, 0, 0, 32'hABCD, 1'b1, 0, 1'b0);

        idle(3);
        done = 1'b1;
    end

    // Monitor
    initial begin
        int   stall_cnt;
        exp_t e;
        stall_cnt = 0;
        while (!done) begin
            @(negedge clk);
            if (reset) begin
                stall_cnt = 0;
            end else if (Valid_ID && Stall_EX) begin
                stall_cnt++;
            end else if (Valid_ID) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL retire: instruction retired with no expectation queued, result %h", ALU_result_EX);
                end else begin
                    e = q.pop_front();
                    chk(e.name, "result", ALU_result_EX, e.res);
                    chk(e.name, "zero", {31'd0, Zero_EX}, {31'd0, e.res == 32'd0});
                    chk(e.name, "wreg", {27'd0, Write_register_EX}, {27'd0, e.wreg});
                    chk(e.name, "regwrite", {31'd0, RegWrite_EX}, {31'd0, e.rw});
                    chk(e.name, "stalls", stall_cnt, e.stall);
                    chk(e.name, "busy", {31'd0, Busy_EX}, {31'd0, e.busy});
                    if (e.chkpc) chk(e.name, "pc_next", PC_next_EX, e.pcn);
                end
                stall_cnt = 0;
            end
        end
        chk("end", "pending", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline, sitting between ID_EX and EX_MEM. It contains:
- the combinational ALU and branch-target adder, producing the ALU result, zero flag, branch target and destination register that EX_MEM captures;
- a multi-cycle HI/LO multiply/divide unit (32-cycle shift-add multiplier and restoring divider) with a stall handshake back to the front end.

## Interface
Parameters:
- none (datapath fixed at 32 bits, register index at 5 bits)

Ports (clock is clk; reset is synchronous, active-high, named reset):
- clk  in  1  pipeline clock, all state updates on posedge
- reset  in  1  synchronous active-high reset
- Valid_ID  in  1  ID_EX holds a real instruction (0 = bubble)
- PC_plus4_ID  in  32  PC+4 of the instruction
- Read_Data_1_ID  in  32  rs operand
- Read_Data_2_ID  in  32  rt operand
- Sign_ext_ID  in  32  sign-extended immediate; [10:6] = shamt, [5:0] = funct
- Rt_ID, Rd_ID  in  5 each  candidate destination registers
- RegDst_ID  in  1  1 selects Rd_ID, 0 selects Rt_ID
- ALUSrc_ID  in  1  1 selects Sign_ext_ID as the B operand
- ALUOp_ID  in  2  00 add, 01 sub, 10 decode funct, 11 reserved (treated as add)
- RegWrite_ID  in  1  instruction writes the GPR file
- ALU_result_EX  out  32  result to EX_MEM
- Zero_EX  out  1  ALU_result_EX == 0
- PC_next_EX  out  32  branch target
- Write_register_EX  out  5  destination register
- RegWrite_EX  out  1  gated register-write enable
- Stall_EX  out  1  hold PC/IF_ID/ID_EX this cycle; EX_MEM must load a bubble
- Busy_EX  out  1  mult/div unit is iterating (debug/observe)

## Operation
- The ALU is combinational. Arithmetic wraps mod 2^32 and never traps.
- ALUOp 10 funct decode:
  - 100000/100001 add
  - 100010/100011 sub
  - 100100 and, 100101 or, 100110 xor, 100111 nor
  - 101010 slt (signed), 101011 sltu
  - 000000 sll, 000010 srl, 000011 sra: shift the B operand by shamt
  - 010000 mfhi and 010010 mflo return HI and LO
  - 010001 mthi, 010011 mtlo, and 0110xx mult/multu/div/divu return 0
  - undefined funct returns 0
- Other outputs:
  - PC_next_EX = PC_plus4_ID + (Sign_ext_ID << 2), independent of ALUOp.
  - Write_register_EX = RegDst_ID ? Rd_ID : Rt_ID.
  - RegWrite_EX = RegWrite_ID & Valid_ID & ~Stall_EX & ~(mthi|mtlo|mult|multu|div|divu).
- HI/LO ops are the funct codes 0100xx and 0110xx with ALUOp 10 and Valid_ID = 1.
- Stall_EX = HI/LO op present & Busy_EX. Non-HI/LO instructions never stall, even while the unit is busy.
- mthi/mtlo, when not stalled, write HI or LO from Read_Data_1_ID at the clock edge.
- Unit FSM has two states:
  - IDLE: a non-stalled mult/multu/div/divu latches its operands, clears the 5-bit counter and moves to BUSY. The instruction itself leaves EX the same cycle.
  - BUSY: performs one iteration per cycle and increments the counter. At the edge where the counter is 31, it writes HI/LO and returns to IDLE.
- Signed ops iterate on magnitudes; the sign is applied on the final write.
  - Product sign = sign(rs) XOR sign(rt).
  - Quotient sign = sign(rs) XOR sign(rt); remainder takes the sign of the dividend.
- Multiply: HI:LO = 64-bit product.
- Divide: LO = quotient, HI = remainder.
- Divide by zero (signed or unsigned): LO = 32'hFFFFFFFF, HI = dividend operand. It still takes 32 cycles.
- Signed 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.

## Timing
- Reset values:
  - HI = LO = 0, FSM = IDLE, counter = 0, Busy_EX = 0.
  - Stall_EX = 0 while reset is high.
  - Combinational outputs follow their inputs.
- A mult/div issued in cycle T gives Busy_EX = 1 in cycles T+1..T+32. HI/LO update at the edge ending T+32. Busy_EX = 0 in T+33.
- A HI/LO op arriving in cycles T+1..T+32 asserts Stall_EX until T+32 inclusive. It proceeds in T+33 and reads the new HI/LO.
- Back-to-back mult then mfhi: 32 stall cycles.
- A HI/LO op in the same cycle that BUSY finishes still stalls; it proceeds the next cycle.
- A stalled instruction must be held stable by upstream. This block takes no action on it until Stall_EX drops.
- Reset asserted mid-BUSY aborts the operation: HI = LO = 0 and FSM = IDLE at the next edge.
- Valid_ID = 0 never starts the unit, never writes HI/LO and never stalls.

## Test plan
- Reset, then add 5+7 with ALUOp 10, RegDst = 1, Rd = 3 -> ALU_result_EX = 12, Zero_EX = 0, Write_register_EX = 3, RegWrite_EX = 1.
- beq-style ALUOp 01 with rs = rt = 9, PC_plus4 = 0x100, imm = 4 -> ALU_result = 0, Zero_EX = 1, PC_next_EX = 0x110.
- mult of -3 and 7, then mflo and mfhi next -> Stall_EX high for exactly 32 cycles; mflo returns 32'hFFFFFFEB, then mfhi returns 32'hFFFFFFFF.
- divu 100/7, then an unrelated add during BUSY, then mfhi -> add does not stall; LO = 14, HI = 2.
- div -7/2 gives LO = -3, HI = -1. div 5/0 gives LO = 32'hFFFFFFFF, HI = 5. div 32'h80000000/-1 gives LO = 32'h80000000, HI = 0.
- Start multu, assert reset at busy cycle 10 -> Busy_EX = 0 and HI = LO = 0 after the edge; a following mthi 0xABCD then mfhi returns 0xABCD with no stall.
